// File: rtl/regwrite_arbiter.sv
// Write-port arbiter for the register bank: two one-entry holding buffers feed a
// single registered write port, round-robin when both buffers hold a write.
// Writes to register 0 consume a grant but never assert the bank write enable.
module regwrite_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_valid_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              busy_o
);

  logic              full0_q, full0_d, full1_q, full1_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic              last_q, last_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              gnt0, gnt1, gnt_any, acc0, acc1;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  // Arbitration looks only at buffer state, so ready never depends on valid.
  always_comb begin
    gnt0     = full0_q & (~full1_q | last_q);
    gnt1     = full1_q & (~full0_q | ~last_q);
    gnt_any  = gnt0 | gnt1;
    gnt_addr = gnt1 ? addr1_q : addr0_q;
    gnt_data = gnt1 ? data1_q : data0_q;
  end

  assign req0_ready_o = ~full0_q | gnt0;
  assign req1_ready_o = ~full1_q | gnt1;
  assign acc0         = req0_valid_i & req0_ready_o;
  assign acc1         = req1_valid_i & req1_ready_o;

  // Buffer drain/refill, round-robin pointer and output register next state.
  always_comb begin
    full0_d   = full0_q;
    full1_d   = full1_q;
    addr0_d   = addr0_q;
    addr1_d   = addr1_q;
    data0_d   = data0_q;
    data1_d   = data1_q;
    last_d    = last_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (gnt0) full0_d = 1'b0;
    if (gnt1) full1_d = 1'b0;
    // A refill in the same edge as the drain keeps the buffer full.
    if (acc0) begin
      full0_d = 1'b1;
      addr0_d = req0_addr_i;
      data0_d = req0_data_i;
    end
    if (acc1) begin
      full1_d = 1'b1;
      addr1_d = req1_addr_i;
      data1_d = req1_data_i;
    end

    if (gnt_any) begin
      last_d    = gnt1;
      wr_en_d   = (gnt_addr != '0);
      wr_addr_d = gnt_addr;
      wr_data_d = gnt_data;
    end
  end

  // State registers; reset empties both buffers and biases the first contention to req0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full0_q   <= 1'b0;
      full1_q   <= 1'b0;
      addr0_q   <= '0;
      addr1_q   <= '0;
      data0_q   <= '0;
      data1_q   <= '0;
      last_q    <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      full0_q   <= full0_d;
      full1_q   <= full1_d;
      addr0_q   <= addr0_d;
      addr1_q   <= addr1_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = full0_q | full1_q;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Self-checking bench for regwrite_arbiter: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_regwrite_arbiter;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req0_valid_i, req1_valid_i;
  logic [AW-1:0] req0_addr_i, req1_addr_i;
  logic [DW-1:0] req0_data_i, req1_data_i;
  logic          req0_ready_o, req1_ready_o;
  logic          wr_en_o, busy_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;

  regwrite_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req0_valid_i (req0_valid_i),
    .req0_addr_i  (req0_addr_i),
    .req0_data_i  (req0_data_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_addr_i  (req1_addr_i),
    .req1_data_i  (req1_data_i),
    .req1_ready_o (req1_ready_o),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: each requester owns a queue of at most one pending write.
  wr_t           m_q0[$], m_q1[$];
  logic          m_last, m_en, m_busy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          e_rdy0, e_rdy1, o_rdy0, o_rdy1;
  // Writes seen on the DUT bank port, with the cycle they appeared in.
  wr_t           dlog[$];
  int            dcyc[$];

  function automatic void model_reset();
    m_q0.delete();
    m_q1.delete();
    m_last = 1'b1;
    m_en   = 1'b0;
    m_busy = 1'b0;
    m_addr = '0;
    m_data = '0;
    dlog.delete();
    dcyc.delete();
  endfunction

  function automatic logic [40:0] model_vec();
    return {m_en, m_addr, m_data, m_busy, e_rdy0, e_rdy1};
  endfunction

  function automatic logic [40:0] dut_vec();
    return {wr_en_o, wr_addr_o, wr_data_o, busy_o, o_rdy0, o_rdy1};
  endfunction

  task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0_valid_i = v0;
    req0_addr_i  = a0;
    req0_data_i  = d0;
    req1_valid_i = v1;
    req1_addr_i  = a1;
    req1_data_i  = d1;
  endtask

  // Advance one clock: sample readys before the edge, update the model, settle #1 after.
  task automatic step();
    int  g;
    wr_t w, n0, n1;
    bit  a0, a1;
    g = -1;
    if (m_q0.size() != 0 && m_q1.size() != 0) g = m_last ? 0 : 1;
    else if (m_q0.size() != 0) g = 0;
    else if (m_q1.size() != 0) g = 1;
    e_rdy0 = (m_q0.size() == 0) || (g == 0);
    e_rdy1 = (m_q1.size() == 0) || (g == 1);
    o_rdy0 = req0_ready_o;
    o_rdy1 = req1_ready_o;
    a0 = req0_valid_i && e_rdy0;
    a1 = req1_valid_i && e_rdy1;
    n0.a = req0_addr_i;
    n0.d = req0_data_i;
    n1.a = req1_addr_i;
    n1.d = req1_data_i;
    @(posedge clk_i);
    m_en = 1'b0;
    if (g >= 0) begin
      if (g == 0) w = m_q0.pop_front();
      else w = m_q1.pop_front();
      m_last = (g == 1);
      m_addr = w.a;
      m_data = w.d;
      m_en   = (w.a != 0);
    end
    if (a0) m_q0.push_back(n0);
    if (a1) m_q1.push_back(n1);
    m_busy = (m_q0.size() != 0) || (m_q1.size() != 0);
    #1;
    cyc++;
    if (wr_en_o === 1'b1) begin
      w.a = wr_addr_o;
      w.d = wr_data_o;
      dlog.push_back(w);
      dcyc.push_back(cyc);
    end
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #2;
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'($urandom), AW'($urandom), $urandom, 1'($urandom), AW'($urandom), $urandom);
    rst_ni = 1'b0;
    #3;
    checks += 6;
    if (wr_en_o !== 1'b0) begin errors++; $display("FAIL reset wr_en got %b want 0", wr_en_o); end
    if (wr_addr_o !== '0) begin errors++; $display("FAIL reset wr_addr got %h want 0", wr_addr_o); end
    if (wr_data_o !== '0) begin errors++; $display("FAIL reset wr_data got %h want 0", wr_data_o); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy_o); end
    if (req0_ready_o !== 1'b1) begin errors++; $display("FAIL reset rdy0 got %b want 1", req0_ready_o); end
    if (req1_ready_o !== 1'b1) begin errors++; $display("FAIL reset rdy1 got %b want 1", req1_ready_o); end
    @(posedge clk_i);
    #1;
    checks += 2;
    if (wr_en_o !== 1'b0) begin errors++; $display("FAIL reset_edge wr_en got %b want 0", wr_en_o); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_edge busy got %b want 0", busy_o); end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_first_write();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    checks += 2;
    if (wr_en_o !== 1'b0) begin errors++; $display("FAIL first_edge1 wr_en got %b want 0", wr_en_o); end
    if (busy_o !== 1'b1) begin errors++; $display("FAIL first_edge1 busy got %b want 1", busy_o); end
    step();
    checks++;
    if ({wr_en_o, wr_addr_o, wr_data_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL first_edge2 got en=%b a=%0d d=%h want en=1 a=5 d=deadbeef",
               wr_en_o, wr_addr_o, wr_data_o);
    end
  endtask

  task automatic test_single_stream();
    do_reset();
    for (int i = 1; i <= 11; i++) begin
      if (i <= 8) drive(1'b0, '0, '0, 1'b1, AW'(i), 32'h100 + i);
      else drive(1'b0, '0, '0, 1'b0, '0, '0);
      step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL stream cyc%0d got %h want %h", i, dut_vec(), model_vec());
      end
      if (i <= 8) begin
        checks++;
        if (o_rdy1 !== 1'b1) begin errors++; $display("FAIL stream_rdy1 cyc%0d got 0 want 1", i); end
      end
    end
    checks++;
    if (dlog.size() != 8) begin
      errors++;
      $display("FAIL stream_count got %0d want 8", dlog.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (dlog[i].a !== AW'(i + 1) || dlog[i].d !== 32'h101 + i || dcyc[i] != dcyc[0] + i) begin
          errors++;
          $display("FAIL stream_order slot%0d got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                   i, dlog[i].a, dlog[i].d, dcyc[i], i + 1, 32'h101 + i, dcyc[0] + i);
        end
      end
    end
  endtask

  task automatic test_contention();
    int   i0, i1;
    logic r0[8], r1[8];
    int   want[6];
    want = '{10, 20, 11, 21, 12, 22};
    r0 = '{default: 1'b0};
    r1 = '{default: 1'b0};
    do_reset();
    i0 = 0;
    i1 = 0;
    for (int k = 0; k < 8; k++) begin
      drive(i0 < 3, AW'(10 + i0), 32'h1000 + 10 + i0, i1 < 3, AW'(20 + i1), 32'h1000 + 20 + i1);
      step();
      r0[k] = o_rdy0;
      r1[k] = o_rdy1;
      if (req0_valid_i && o_rdy0) i0++;
      if (req1_valid_i && o_rdy1) i1++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL contend cyc%0d got %h want %h", k, dut_vec(), model_vec());
      end
    end
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (r0[k] !== 1'(k % 2) || r1[k] !== 1'((k + 1) % 2)) begin
        errors++;
        $display("FAIL contend_rdy cyc%0d got %b%b want %b%b", k, r0[k], r1[k], k % 2, (k + 1) % 2);
      end
    end
    checks++;
    if (dlog.size() != 6) begin
      errors++;
      $display("FAIL contend_count got %0d want 6", dlog.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (dlog[k].a !== AW'(want[k])) begin
          errors++;
          $display("FAIL contend_order slot%0d got %0d want %0d", k, dlog[k].a, want[k]);
        end
      end
    end
  endtask

  task automatic test_reg_zero();
    logic en_slot1;
    do_reset();
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0);
    step();
    drive(1'b1, 5'd3, 32'h7, 1'b0, '0, '0);
    step();
    en_slot1 = wr_en_o;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    checks += 2;
    if (en_slot1 !== 1'b0) begin errors++; $display("FAIL zero_slot got en=%b want 0", en_slot1); end
    if ({wr_en_o, wr_addr_o, wr_data_o} !== {1'b1, 5'd3, 32'h7}) begin
      errors++;
      $display("FAIL zero_next got en=%b a=%0d d=%h want en=1 a=3 d=7", wr_en_o, wr_addr_o, wr_data_o);
    end
    // req1 grant sets pointer to 1; an address-0 grant from req0 must move it back to 0.
    drive(1'b0, '0, '0, 1'b1, 5'd4, 32'h4);
    step();
    drive(1'b1, 5'd0, 32'h1, 1'b0, '0, '0);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    drive(1'b1, 5'd6, 32'h60, 1'b1, 5'd7, 32'h70);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL zero cyc%0d got %h want %h", k, dut_vec(), model_vec());
      end
    end
    checks++;
    if (dlog.size() != 4 || dlog[2].a !== 5'd7 || dlog[3].a !== 5'd6) begin
      errors++;
      $display("FAIL zero_last count=%0d want 4 with writes 7 then 6", dlog.size());
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] final_v;
    do_reset();
    drive(1'b1, 5'd1, 32'h1, 1'b0, '0, '0);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    drive(1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB);
    step();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL collide cyc%0d got %h want %h", k, dut_vec(), model_vec());
      end
    end
    final_v = '0;
    foreach (dlog[k]) if (dlog[k].a == 5'd9) final_v = dlog[k].d;
    checks += 2;
    if (dlog.size() != 3 || dlog[1].d !== 32'hB || dlog[2].d !== 32'hA) begin
      errors++;
      $display("FAIL collide_order count=%0d want 3 with data B then A", dlog.size());
    end
    if (final_v !== 32'hA) begin
      errors++;
      $display("FAIL collide_final got %h want a", final_v);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive(1'b1, 5'd10, 32'h10, 1'b1, 5'd20, 32'h20);
    step();
    drive(1'b1, 5'd11, 32'h11, 1'b1, 5'd21, 32'h21);
    step();
    checks++;
    if (wr_en_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre got en=%b busy=%b want 1 1", wr_en_o, busy_o);
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    #2;
    rst_ni = 1'b0;
    #1;
    checks += 2;
    if (wr_en_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_now got en=%b busy=%b want 0 0", wr_en_o, busy_o);
    end
    if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_rdy got %b%b want 11", req0_ready_o, req1_ready_o);
    end
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL midrst cyc%0d got %h want %h", k, dut_vec(), model_vec());
      end
    end
    checks++;
    if (dlog.size() != 0) begin errors++; $display("FAIL midrst_stale got %0d writes want 0", dlog.size()); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a0, a1;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      a0 = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
      a1 = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
      drive($urandom_range(0, 9) < 7, a0, $urandom, $urandom_range(0, 9) < 6, a1, $urandom);
      step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random cyc%0d got %h want %h", k, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    model_reset();
    e_rdy0 = 1'b1;
    e_rdy1 = 1'b1;
    o_rdy0 = 1'b1;
    o_rdy1 = 1'b1;
    test_reset();
    test_first_write();
    test_single_stream();
    test_contention();
    test_reg_zero();
    test_collision();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
